// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_defs: shared types and constants for the memory/bus controller.
// Holds the controller state encoding, the address-region encoding, the
// wait-state counter width and a helper that clamps a wait count to the
// range the counter can hold.
package mem_bus_defs;

    // Width of the wait-state down-counter.
    localparam int CNT_W    = 4;

    // Largest wait count the counter is ever loaded with; larger requests
    // are clamped so the counter never wraps.
    localparam int MAX_WAIT = 14;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAITS = 3'd2,
        XFER  = 3'd3,
        RCAP  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Address regions.
    typedef enum logic {
        REGION_RAM = 1'b0,
        REGION_IO  = 1'b1
    } region_e;

    // Clamp a requested wait count into 0..MAX_WAIT.
    function automatic logic [CNT_W-1:0] clamp_wait(input int w);
        if (w > MAX_WAIT) begin
            return CNT_W'(MAX_WAIT);
        end else if (w < 0) begin
            return '0;
        end else begin
            return CNT_W'(w);
        end
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: bundle of the core-side bus strobes and the memory-side
// signals seen by the memory/bus controller.
//   slave  : the controller's view (consumes core strobes and memory data).
//   master : the environment's view (core plus memory).
interface mem_bus_ctrl_if;

    // Core side.
    logic [15:0] BusData_in;
    logic [15:0] BusData_out;
    logic        ENB;
    logic        ALE;
    logic        nME;
    logic        RnW;
    logic        nOE;
    logic        nWait;

    // Memory side.
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemWe;
    logic        MemRe;
    logic [15:0] MemRData;

    // Status.
    logic        WrFault;

    modport slave (
        input  BusData_in, ENB, ALE, nME, RnW, nOE, MemRData,
        output BusData_out, nWait, MemAddr, MemWData, MemWe, MemRe, WrFault
    );

    modport master (
        output BusData_in, ENB, ALE, nME, RnW, nOE, MemRData,
        input  BusData_out, nWait, MemAddr, MemWData, MemWe, MemRe, WrFault
    );

endinterface

// File: rtl/mem_bus_ctrl_region_decode.sv
// mem_region_decode: purely combinational address decoder. Classifies an
// address as RAM or IO (IO is everything at or above IO_BASE) and returns
// the clamped wait-state count for that region.
module mem_region_decode
    import mem_bus_defs::*;
#(
    parameter logic [15:0] IO_BASE  = 16'hF000,
    parameter int          RAM_WAIT = 0,
    parameter int          IO_WAIT  = 2
) (
    input  logic [15:0]      i_addr,
    output region_e          o_region,
    output logic [CNT_W-1:0] o_wait_cnt
);

    // Wait counts are fixed per build, so clamp them once here.
    localparam logic [CNT_W-1:0] RAM_CNT = clamp_wait(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_CNT  = clamp_wait(IO_WAIT);

    // Region select: RAM unless the address reaches the IO window.
    always_comb begin
        o_region   = REGION_RAM;
        o_wait_cnt = RAM_CNT;
        if (i_addr >= IO_BASE) begin
            o_region   = REGION_IO;
            o_wait_cnt = IO_CNT;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges the core's multiplexed address/data bus strobes
// (ALE, nME, RnW, nOE, ENB) to a synchronous single-port memory.
// The address is latched on ALE, nME low starts the access, the core is
// stalled through nWait for the region's wait states, then a one-cycle
// MemWe or MemRe strobe is issued. Read data arrives on MemRData one cycle
// after MemRe and is registered onto BusData_out.
// Optional build macro: MEM_WRITE_PROTECT_EN -- writes at or below ROM_TOP
// are dropped and raise a sticky WrFault flag. Without it all writes are
// performed and WrFault is tied low.
module mem_bus_ctrl
    import mem_bus_defs::*;
#(
    parameter logic [15:0] IO_BASE  = 16'hF000,
    parameter int          RAM_WAIT = 0,
    parameter int          IO_WAIT  = 2,
    parameter logic [15:0] ROM_TOP  = 16'h0FFF
) (
    input  logic           Clock,
    input  logic           Reset,
    mem_bus_ctrl_if.slave  bus
);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt,   w_cnt_next;
    logic             r_rnw,   w_rnw_next;
    logic             r_nwait, w_nwait_next;
    logic             r_mem_we, w_mem_we_next;
    logic             r_mem_re, w_mem_re_next;
    logic [15:0]      r_addr,  w_addr_next;
    logic [15:0]      r_wdata, w_wdata_next;
    logic [15:0]      r_rdata, w_rdata_next;

    region_e          w_region;
    logic [CNT_W-1:0] w_wait_cnt;
    logic             w_protected;

    // Region and wait count always follow the latched address, so the
    // counter load in ADDR sees the final (possibly re-latched) address.
    mem_region_decode #(
        .IO_BASE  (IO_BASE),
        .RAM_WAIT (RAM_WAIT),
        .IO_WAIT  (IO_WAIT)
    ) u_region_decode (
        .i_addr     (r_addr),
        .o_region   (w_region),
        .o_wait_cnt (w_wait_cnt)
    );

`ifdef MEM_WRITE_PROTECT_EN
    logic r_wr_fault;
    logic w_fault_set;

    // Only RAM-region addresses can fall inside the protected ROM window.
    assign w_protected = (w_region == REGION_RAM) && (r_addr <= ROM_TOP);

    // A fault is recorded on the same edge a real write would have strobed.
    assign w_fault_set = (r_state == XFER) && !bus.nME && !r_rnw &&
                         bus.ENB && w_protected;

    // Sticky fault flag: set by a blocked write, cleared only by reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_fault <= 1'b0;
        end else if (w_fault_set) begin
            r_wr_fault <= 1'b1;
        end
    end

    assign bus.WrFault = r_wr_fault;
`else
    // Region and ROM boundary have no consumer when protection is off.
    logic w_unused_region;
    assign w_unused_region = (w_region == REGION_IO) ^ (ROM_TOP == 16'h0000);

    assign w_protected = 1'b0;
    assign bus.WrFault = 1'b0;
`endif

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rnw    <= 1'b1;
            r_nwait  <= 1'b1;
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_rnw    <= w_rnw_next;
            r_nwait  <= w_nwait_next;
            r_mem_we <= w_mem_we_next;
            r_mem_re <= w_mem_re_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_rdata  <= w_rdata_next;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_rnw_next    = r_rnw;
        w_nwait_next  = r_nwait;
        w_mem_we_next = 1'b0;
        w_mem_re_next = 1'b0;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_rdata_next  = r_rdata;

        case (r_state)
            IDLE: begin
                w_nwait_next = 1'b1;
                if (bus.ALE) begin
                    w_addr_next  = bus.BusData_in;
                    w_state_next = ADDR;
                end
            end

            ADDR: begin
                // A repeated ALE wins over nME so the address is final
                // before the wait count is chosen.
                if (bus.ALE) begin
                    w_addr_next = bus.BusData_in;
                end else if (!bus.nME) begin
                    w_rnw_next   = bus.RnW;
                    w_cnt_next   = w_wait_cnt;
                    w_nwait_next = 1'b0;
                    w_state_next = WAITS;
                end
            end

            WAITS: begin
                if (bus.nME) begin
                    w_nwait_next = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = XFER;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end

            XFER: begin
                // Abort has priority so no strobe escapes a cancelled access.
                if (bus.nME) begin
                    w_nwait_next = 1'b1;
                    w_state_next = IDLE;
                end else if (!r_rnw) begin
                    if (bus.ENB) begin
                        w_wdata_next  = bus.BusData_in;
                        w_mem_we_next = !w_protected;
                        w_nwait_next  = 1'b1;
                        w_state_next  = DONE;
                    end
                end else if (!bus.nOE) begin
                    w_mem_re_next = 1'b1;
                    w_state_next  = RCAP;
                end
            end

            RCAP: begin
                // While the strobe is still out the memory has not answered;
                // the data is on MemRData in the cycle after the strobe.
                if (!r_mem_re) begin
                    w_rdata_next = bus.MemRData;
                    w_nwait_next = 1'b1;
                    w_state_next = DONE;
                end
            end

            DONE: begin
                w_nwait_next = 1'b1;
                if (bus.nME) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_nwait_next = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.BusData_out = r_rdata;
    assign bus.nWait       = r_nwait;
    assign bus.MemAddr     = r_addr;
    assign bus.MemWData    = r_wdata;
    assign bus.MemWe       = r_mem_we;
    assign bus.MemRe       = r_mem_re;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: self-checking bench for mem_bus_ctrl. Each expected
// memory strobe is pushed to a queue when an access is driven; a monitor
// pops and compares it when MemWe/MemRe appears. Timing, nWait and read
// data are compared inline in each scenario task.
module tb_mem_bus_ctrl;

    localparam logic [15:0] IO_BASE_T  = 16'hF000;
    localparam int          RAM_WAIT_T = 0;
    localparam int          IO_WAIT_T  = 2;
    localparam logic [15:0] ROM_TOP_T  = 16'h0FFF;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] rd_value;
    exp_t        exp_q[$];
    int          n_tests;
    int          n_fails;

    mem_bus_ctrl_if bus();

    mem_bus_ctrl #(
        .IO_BASE  (IO_BASE_T),
        .RAM_WAIT (RAM_WAIT_T),
        .IO_WAIT  (IO_WAIT_T),
        .ROM_TOP  (ROM_TOP_T)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data only valid in the cycle right after MemRe.
    always @(posedge clk) begin
        bus.MemRData <= (bus.MemRe === 1'b1) ? rd_value : 16'h0BAD;
    end

    // Strobe monitor: every strobe must match the oldest expected access.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.MemWe === 1'b1 || bus.MemRe === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL strobe_unexpected: got we=%b re=%b addr=%h, expected no strobe",
                             bus.MemWe, bus.MemRe, bus.MemAddr);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.MemWe !== e.we || bus.MemRe !== !e.we || bus.MemAddr !== e.addr ||
                        (e.we && bus.MemWData !== e.data)) begin
                        n_fails++;
                        $display("FAIL strobe_match: got we=%b re=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                                 bus.MemWe, bus.MemRe, bus.MemAddr, bus.MemWData, e.we, e.addr, e.data);
                    end else begin
                        $display("[TB] strobe %s addr=%h data=%h ok", e.we ? "WR" : "RD",
                                 e.addr, e.we ? bus.MemWData : e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input logic [15:0] a);
        return (a >= IO_BASE_T) ? IO_WAIT_T : RAM_WAIT_T;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.ALE        = 1'b0;
        bus.nME        = 1'b1;
        bus.RnW        = 1'b1;
        bus.nOE        = 1'b1;
        bus.ENB        = 1'b0;
        bus.BusData_in = 16'h0000;
    endtask

    // Drives one full access. Cycle c is the cycle after the c-th edge
    // counted from the edge that samples nME low. ENB is first sampled
    // high at edge enb_at. Reports when the strobe and nWait rise appear.
    task automatic do_access(input logic [15:0] addr, input logic rnw, input logic [15:0] data,
                             input int enb_at, output int strobe_cyc, output int strobe_cnt,
                             output int rise_cyc, output int nwait_low);
        strobe_cyc = -1;
        strobe_cnt = 0;
        rise_cyc   = -1;
        nwait_low  = 0;
        bus.BusData_in = addr;
        bus.ALE        = 1'b1;
        tick();
        bus.ALE        = 1'b0;
        bus.nME        = 1'b0;
        bus.RnW        = rnw;
        bus.nOE        = rnw ? 1'b0 : 1'b1;
        rd_value       = data;
        bus.ENB        = !rnw && (enb_at <= 0);
        bus.BusData_in = bus.ENB ? data : 16'h1111;
        for (int c = 0; c < 40; c++) begin
            tick();
            bus.RnW = ~rnw;
            if (rnw) begin
                bus.ALE        = (c == 0);
                bus.BusData_in = (c == 0) ? 16'hFFFF : 16'h0000;
            end else begin
                bus.ENB        = (c + 1 >= enb_at);
                bus.BusData_in = bus.ENB ? data : 16'h1111;
            end
            if ((rnw ? bus.MemRe : bus.MemWe) === 1'b1) begin
                strobe_cnt++;
                if (strobe_cyc < 0) strobe_cyc = c;
            end
            if (bus.nWait === 1'b0) begin
                nwait_low++;
            end else if (bus.nWait === 1'b1) begin
                rise_cyc = c;
                break;
            end
        end
        tick();
        if ((rnw ? bus.MemRe : bus.MemWe) === 1'b1) strobe_cnt++;
        bus_idle();
        tick();
        tick();
    endtask

    task automatic check_queue_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_missing_strobe: got %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus_idle();
        rd_value = 16'h0000;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bus.nWait, bus.MemWe, bus.MemRe} !== 3'b100) begin
            n_fails++;
            $display("FAIL reset_strobes: got nWait/We/Re=%b%b%b, expected 100", bus.nWait, bus.MemWe, bus.MemRe);
        end
        n_tests++;
        if ({bus.BusData_out, bus.MemAddr, bus.MemWData} !== 48'h0) begin
            n_fails++;
            $display("FAIL reset_data: got out=%h addr=%h wdata=%h, expected all 0",
                     bus.BusData_out, bus.MemAddr, bus.MemWData);
        end
        n_tests++;
        if (bus.WrFault !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_wrfault: got %b, expected 0", bus.WrFault);
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    // Generic access with inline timing/data checks against expectations.
    task automatic run_checked(input string name, input logic [15:0] addr, input logic rnw,
                               input logic [15:0] data, input int enb_at, input int exp_strobe);
        int sc, cnt, rise, low, exp_rise;
        exp_t e;
        e.we = !rnw; e.addr = addr; e.data = data;
        exp_q.push_back(e);
        exp_rise = rnw ? exp_strobe + 2 : exp_strobe;
        do_access(addr, rnw, data, enb_at, sc, cnt, rise, low);
        n_tests++;
        if (sc !== exp_strobe || cnt !== 1) begin
            n_fails++;
            $display("FAIL %s_strobe: got cycle %0d count %0d, expected cycle %0d count 1", name, sc, cnt, exp_strobe);
        end
        n_tests++;
        if (rise !== exp_rise || low !== exp_rise) begin
            n_fails++;
            $display("FAIL %s_nwait: got rise %0d low %0d, expected rise %0d low %0d", name, rise, low, exp_rise, exp_rise);
        end
        if (rnw) begin
            n_tests++;
            if (bus.BusData_out !== data) begin
                n_fails++;
                $display("FAIL %s_rdata: got %h, expected %h", name, bus.BusData_out, data);
            end
        end
        check_queue_empty(name);
        $display("[TB] %s addr=%h %s data=%h strobe@%0d rise@%0d", name, addr, rnw ? "RD" : "WR", data, sc, rise);
    endtask

    task automatic test_ram_read();
        run_checked("ram_read", 16'h0123, 1'b1, 16'hBEEF, 0, RAM_WAIT_T + 2);
    endtask

    task automatic test_io_write();
        run_checked("io_write", 16'hF004, 1'b0, 16'h5A5A, 0, IO_WAIT_T + 2);
        n_tests++;
        if (bus.MemAddr !== 16'hF004 || bus.MemWData !== 16'h5A5A) begin
            n_fails++;
            $display("FAIL io_write_regs: got addr=%h wdata=%h, expected F004/5A5A", bus.MemAddr, bus.MemWData);
        end
    endtask

    task automatic test_enb_late();
        // ENB held low for three XFER cycles, sampled high on the fourth.
        run_checked("enb_late", 16'h0456, 1'b0, 16'hC3C3, RAM_WAIT_T + 5, RAM_WAIT_T + 5);
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [5] = '{16'h1000, 16'h1000, 16'hF000, 16'hEFFF, 16'hFFFF};
        logic        rnws  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] datas [5] = '{16'hA1A1, 16'h7E7E, 16'h0F0F, 16'h3C3C, 16'h9999};
        for (int i = 0; i < 5; i++) begin
            run_checked("b2b", addrs[i], rnws[i], datas[i], 0, wait_of(addrs[i]) + 2);
        end
    endtask

    task automatic test_abort();
        int strobes, low;
        // Abort an IO read during its wait states.
        bus.BusData_in = 16'hF008;
        bus.ALE = 1'b1;
        tick();
        bus.ALE = 1'b0;
        bus.nME = 1'b0; bus.RnW = 1'b1; bus.nOE = 1'b0;
        tick();
        tick();
        bus.nME = 1'b1; bus.nOE = 1'b1;
        tick();
        n_tests++;
        if (bus.nWait !== 1'b1) begin
            n_fails++;
            $display("FAIL abort_waits_nwait: got %b, expected 1", bus.nWait);
        end
        // Back in IDLE: nME without ALE must not start an access.
        strobes = 0; low = 0;
        bus.nME = 1'b0; bus.nOE = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.MemRe === 1'b1 || bus.MemWe === 1'b1) strobes++;
            if (bus.nWait !== 1'b1) low++;
        end
        bus_idle();
        tick();
        n_tests++;
        if (strobes !== 0 || low !== 0) begin
            n_fails++;
            $display("FAIL abort_waits_idle: got strobes %0d stalls %0d, expected 0 0", strobes, low);
        end
        // Abort a RAM write stuck in XFER, dropping nME as ENB rises.
        bus.BusData_in = 16'h0500;
        bus.ALE = 1'b1;
        tick();
        bus.ALE = 1'b0;
        bus.nME = 1'b0; bus.RnW = 1'b0; bus.ENB = 1'b0;
        for (int c = 0; c < RAM_WAIT_T + 3; c++) tick();
        bus.nME = 1'b1; bus.ENB = 1'b1; bus.BusData_in = 16'h7777;
        strobes = 0;
        tick();
        n_tests++;
        if (bus.nWait !== 1'b1 || bus.MemWe !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_xfer: got nWait=%b MemWe=%b, expected 1 0", bus.nWait, bus.MemWe);
        end
        bus_idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.MemWe === 1'b1) strobes++;
        end
        n_tests++;
        if (strobes !== 0) begin
            n_fails++;
            $display("FAIL abort_xfer_strobe: got %0d, expected 0", strobes);
        end
        check_queue_empty("abort");
        $display("[TB] abort scenarios done");
    endtask

    task automatic test_reset_mid_xfer();
        int strobes;
        bus.BusData_in = 16'h0300;
        bus.ALE = 1'b1;
        tick();
        bus.ALE = 1'b0;
        bus.nME = 1'b0; bus.RnW = 1'b0; bus.ENB = 1'b0;
        for (int c = 0; c < RAM_WAIT_T + 2; c++) tick();
        // Now in XFER: reset lands on the edge that would have written.
        rst = 1'b1; bus.ENB = 1'b1; bus.BusData_in = 16'h6666;
        tick();
        n_tests++;
        if ({bus.nWait, bus.MemWe, bus.MemRe} !== 3'b100 ||
            {bus.BusData_out, bus.MemAddr, bus.MemWData} !== 48'h0) begin
            n_fails++;
            $display("FAIL reset_mid_xfer: got nWait/We/Re=%b%b%b out=%h addr=%h wdata=%h, expected 100 and zeros",
                     bus.nWait, bus.MemWe, bus.MemRe, bus.BusData_out, bus.MemAddr, bus.MemWData);
        end
        rst = 1'b0;
        bus_idle();
        strobes = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.MemWe === 1'b1 || bus.MemRe === 1'b1) strobes++;
        end
        n_tests++;
        if (strobes !== 0) begin
            n_fails++;
            $display("FAIL reset_mid_xfer_strobe: got %0d, expected 0", strobes);
        end
        check_queue_empty("reset_mid_xfer");
        $display("[TB] reset mid-XFER done");
    endtask

    task automatic test_write_protect();
`ifdef MEM_WRITE_PROTECT_EN
        int sc, cnt, rise, low;
        do_access(16'h0010, 1'b0, 16'h1234, 0, sc, cnt, rise, low);
        n_tests++;
        if (cnt !== 0 || rise !== RAM_WAIT_T + 2) begin
            n_fails++;
            $display("FAIL wp_blocked: got strobes %0d rise %0d, expected 0 and %0d", cnt, rise, RAM_WAIT_T + 2);
        end
        n_tests++;
        if (bus.WrFault !== 1'b1) begin
            n_fails++;
            $display("FAIL wp_fault_set: got %b, expected 1", bus.WrFault);
        end
        $display("[TB] protected write addr=0010 rise@%0d fault=%b", rise, bus.WrFault);
        run_checked("wp_legal", 16'h2000, 1'b0, 16'h4321, 0, RAM_WAIT_T + 2);
        n_tests++;
        if (bus.WrFault !== 1'b1) begin
            n_fails++;
            $display("FAIL wp_fault_sticky: got %b, expected 1", bus.WrFault);
        end
`else
        run_checked("rom_write", 16'h0010, 1'b0, 16'h1234, 0, RAM_WAIT_T + 2);
        n_tests++;
        if (bus.WrFault !== 1'b0) begin
            n_fails++;
            $display("FAIL wrfault_tied: got %b, expected 0", bus.WrFault);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        test_reset();
        test_ram_read();
        test_io_write();
        test_enb_late();
        test_back_to_back();
        test_abort();
        test_reset_mid_xfer();
        test_write_protect();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
